// File: rtl/zube_mailbox_arbiter.sv
// Round-robin arbiter sharing the byte-wide mailbox RAM between wishbone and the external bus.
// Optional conflict counter: define ZUBE_ARB_STATS_EN to add conflict_count_out.
module zube_mailbox_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              wb_cyc_in,
  input  logic              wb_stb_in,
  input  logic              wb_we_in,
  input  logic [31:0]       wb_addr_in,
  input  logic [31:0]       wb_data_in,
  output logic              wb_ack_out,
  output logic [31:0]       wb_data_out,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [7:0]        ext_wdata,
  output logic              ext_ack,
  output logic [7:0]        ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              irq_out
`ifdef ZUBE_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_count_out
`endif
);

  localparam logic [ADDR_W-1:0] DoorbellAddr = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              gnt_ext_q, gnt_ext_d;
  logic              last_ext_q, last_ext_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              abort_q, abort_d;
  logic              irq_q, irq_d;

  logic wb_hit, wb_req, grant_ext;
  logic unused_bits;

  assign unused_bits = ^{wb_addr_in[1:0], wb_data_in[31:8]};
  assign wb_hit      = (wb_addr_in[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign wb_req      = wb_cyc_in & wb_stb_in & wb_hit;
  // Under conflict, the side that did not win last time gets the grant.
  assign grant_ext   = ext_req & (~wb_req | ~last_ext_q);
  assign irq_out     = irq_q;

  always_comb begin
    state_d     = state_q;
    gnt_ext_d   = gnt_ext_q;
    last_ext_d  = last_ext_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    abort_d     = abort_q;
    irq_d       = irq_q;
    wb_ack_out  = 1'b0;
    wb_data_out = 32'h0;
    ext_ack     = 1'b0;
    ext_rdata   = 8'h0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 8'h0;
    unique case (state_q)
      StIdle: begin
        if (wb_req || ext_req) begin
          gnt_ext_d  = grant_ext;
          last_ext_d = grant_ext;
          we_d       = grant_ext ? ext_we : wb_we_in;
          addr_d     = grant_ext ? ext_addr : wb_addr_in[ADDR_W+1:2];
          wdata_d    = grant_ext ? ext_wdata : wb_data_in[7:0];
          abort_d    = 1'b0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (!gnt_ext_q && !wb_cyc_in) abort_d = 1'b1;
        // Doorbell updates here so irq_out already reflects it during the ack cycle.
        if (gnt_ext_q && we_q && (addr_q == DoorbellAddr)) begin
          irq_d = 1'b1;
        end else if (!gnt_ext_q && !we_q && (addr_q == DoorbellAddr)) begin
          irq_d = 1'b0;
        end
        state_d = StResp;
      end
      StResp: begin
        if (gnt_ext_q) begin
          ext_ack   = 1'b1;
          ext_rdata = mem_rdata;
        end else if (wb_cyc_in && !abort_q) begin
          wb_ack_out  = 1'b1;
          wb_data_out = {24'h0, mem_rdata};
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      gnt_ext_q  <= 1'b0;
      last_ext_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h0;
      abort_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_ext_q  <= gnt_ext_d;
      last_ext_q <= last_ext_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      abort_q    <= abort_d;
      irq_q      <= irq_d;
    end
  end

`ifdef ZUBE_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if ((state_q == StIdle) && wb_req && ext_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) conflict_q <= 16'h0;
    else          conflict_q <= conflict_d;
  end

  assign conflict_count_out = conflict_q;
`endif

endmodule

// File: doc/zube_mailbox_arbiter.md
Name: zube_mailbox_arbiter

Overview:
- Shares one single-port byte-wide mailbox RAM between two requesters: the Caravel wishbone slave port and the external Z80-side bus engine driving GPIO[35:8].
- Round-robin arbitration, one access per grant, fixed 3-cycle request-to-ack latency.
- Raises a doorbell interrupt to the PicoRV32 when the external side writes the top mailbox byte.
- Instantiated inside zube_wrapper, between the wishbone inputs and the mailbox RAM macro.

Parameters:
- ADDR_W, 8, mailbox address width; DEPTH = 2**ADDR_W bytes.
- BASE_ADDR, 32'h3000_0000, wishbone base address; a request hits when wb_addr_in[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].

Ports:
- clk  input  1  system clock (wb_clk_i).
- reset_b  input  1  asynchronous active-low reset.
- wb_cyc_in  input  1  wishbone cycle.
- wb_stb_in  input  1  wishbone strobe.
- wb_we_in  input  1  wishbone write enable.
- wb_addr_in  input  32  wishbone byte address; word index wb_addr_in[ADDR_W+1:2] selects the mailbox byte.
- wb_data_in  input  32  write data; only [7:0] is used.
- wb_ack_out  output  1  single-cycle ack.
- wb_data_out  output  32  {24'b0, byte} while ack is high, else 0.
- ext_req  input  1  external request, level, held until ext_ack.
- ext_we  input  1  external write enable.
- ext_addr  input  ADDR_W  external address.
- ext_wdata  input  8  external write data.
- ext_ack  output  1  single-cycle ack.
- ext_rdata  output  8  read data, valid while ext_ack is high, else 0.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  8  RAM write data.
- mem_rdata  input  8  RAM read data, valid the cycle after mem_en.
- irq_out  output  1  doorbell interrupt, level.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, last_grant = EXT (so WB wins the first conflict), irq_out = 0. Reset is asynchronous and takes effect mid-access: any ack drops immediately and an in-flight access is abandoned.
- wb_req = wb_cyc_in & wb_stb_in & address hit. A miss is never acked and never touches the RAM.
- FSM states:
  - IDLE: if exactly one request is pending, grant it. If both are pending, grant the requester not in last_grant. Latch we/addr/wdata from the granted side, update last_grant, go to ACCESS.
  - ACCESS: mem_en = 1, mem_we/mem_addr/mem_wdata from the latched values. Go to RESP.
  - RESP: the granted side's ack = 1 for exactly one cycle. Read data = mem_rdata (zero-extended on wishbone). Go to IDLE.
- Latency: request sampled in IDLE at cycle N, RAM access at N+1, ack at N+2. Back-to-back accesses are served every 3 cycles.
- Wishbone abort: if wb_cyc_in falls during ACCESS or RESP, wb_ack_out is suppressed. A write issued in ACCESS is still committed.
- ext_req still high in the IDLE cycle after ext_ack is treated as a new request.
- Mailbox address DEPTH-1 is the doorbell:
  - An EXT write to it sets irq_out in the RESP cycle.
  - A WB read of it clears irq_out in the RESP cycle.
  - A set and a clear in the same cycle cannot happen (one grant at a time). If one did, set wins.
- wb_data_out and ext_rdata are 0 outside their own ack cycle.

Optional Feature:
- Macro: ZUBE_ARB_STATS_EN.
- Defined:
  - Adds output conflict_count_out[15:0], reset to 0.
  - Increments in each IDLE cycle where wb_req and ext_req are both pending and a grant is made.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- WB write 0x5A to byte 3 (addr 0x3000_000C), then WB read of the same address -> mem_we=1, mem_addr=3 in ACCESS; each ack arrives exactly 2 cycles after the request is sampled; wb_data_out=0x0000_005A.
- wb_req and ext_req (read, addr 7) asserted in the same cycle after reset -> WB is served first, EXT ack follows 3 cycles later. Repeat the simultaneous requests -> EXT is served first; stats count = 2 when ZUBE_ARB_STATS_EN is defined.
- EXT writes 0x01 to addr 0xFF -> irq_out=1 in the RESP cycle. WB writes addr 0x3000_03FC -> irq_out stays 1. WB reads addr 0x3000_03FC -> returns 0x01 and irq_out=0.
- WB read of 0x3000_0400 (miss, ADDR_W=8) -> no mem_en, no ack for 10 cycles.
- WB write starts, wb_cyc_in drops during ACCESS -> no wb_ack_out; a later read returns the written value.
- reset_b asserted low in RESP -> wb_ack_out, ext_ack and irq_out go to 0 immediately. After release, the FSM is in IDLE and the first conflict grants WB.
